ibex_rf_wr_arbiter: RTL and testbench
=====================================

Name: ibex_rf_wr_arbiter

Overview:
- Sequences and shares the single register-file write port (we/waddr/wdata) between the primary writeback stage and a secondary late-writeback source (e.g. delayed load/multi-cycle responses).
- Performs a secure wipe of every register on reset and on request.
- Exports the pending secondary write so ID-stage hazard logic can stall.

Parameters:
RV32E, 0, 1 selects 16 registers (4-bit address space), else 32.
DataWidth, 32, write data width.
WipeOnReset, 1, 1 starts a full wipe after reset deassertion; 0 starts in RUN.
WipeVal, '0 (DataWidth bits), value written to each register during a wipe.
StarveLimit, 4, number of consecutive cycles a buffered secondary write may be blocked before it takes priority (1..15).

Ports:
clk_i  in  1  clock
rst_ni  in  1  reset; asynchronous, active-low
wipe_req_i  in  1  pulse requesting a wipe; ignored while a wipe is already in progress
wipe_busy_o  out  1  wipe in progress
prim_we_i  in  1  primary write valid
prim_waddr_i  in  5  primary address
prim_wdata_i  in  DataWidth  primary data
prim_ready_o  out  1  primary write accepted this cycle (combinational)
sec_valid_i  in  1  secondary write valid
sec_waddr_i  in  5  secondary address
sec_wdata_i  in  DataWidth  secondary data
sec_ready_o  out  1  secondary accepted into buffer (registered)
sec_pend_o  out  1  buffer holds a not-yet-written entry
sec_pend_addr_o  out  5  address of the pending entry
we_a_o  out  1  register-file write enable
waddr_a_o  out  5  register-file write address
wdata_a_o  out  DataWidth  register-file write data
err_o  out  1  protocol error: sec_valid_i asserted with sec_waddr_i bit 4 set while RV32E=1

Behaviour:
- FSM states: WIPE, RUN.
- Reset: state is WIPE if WipeOnReset=1, else RUN. Wipe counter resets to 1. Buffer is empty, starvation counter resets to 0.
- Reset-time output values: wipe_busy_o = WipeOnReset; sec_ready_o=0; sec_pend_o=0; sec_pend_addr_o=0; err_o=0. we_a_o, waddr_a_o and wdata_a_o are 0 whenever the selected source is idle.
- WIPE:
  - One write per cycle: we_a_o=1, waddr_a_o=counter, wdata_a_o=WipeVal.
  - Counter runs 1..NUM_WORDS-1; R0 is never written.
  - After writing NUM_WORDS-1, the FSM goes to RUN the next cycle. A wipe therefore lasts NUM_WORDS-1 cycles (31, or 15 when RV32E=1).
  - prim_ready_o=0 and sec_ready_o=0 throughout.
  - Entering WIPE from RUN discards the buffer and clears the starvation counter, so no pre-wipe data can land after the wipe.
- RUN, wipe_req_i=1: any primary write presented that cycle is still accepted and written. The FSM goes to WIPE next cycle with counter=1.
- RUN, priority:
  - If the buffer is valid and the starvation counter >= StarveLimit: the buffer writes, prim_ready_o=0.
  - Else if prim_we_i=1: the primary writes, prim_ready_o=1.
  - Else if the buffer is valid: the buffer writes.
  - prim_ready_o=1 whenever the primary is not blocked, including when prim_we_i=0.
- Starvation counter:
  - Increments each cycle the buffer is valid but not written.
  - Clears when the buffer is written or emptied.
  - Saturates at 15.
- Secondary buffer:
  - One entry. sec_ready_o = RUN && !buffer valid, registered (depends on the buffer state at the start of the cycle).
  - An entry accepted in cycle N writes in cycle N+1 at the earliest. Back-to-back secondary accepts are therefore at most every 2 cycles.
  - A write from the buffer and a new accept never happen in the same cycle.
- WAW hazard: if the primary writes the same address as the valid buffer entry and the address is nonzero, the buffer entry is dropped in that cycle (the primary is newer). sec_pend_o falls next cycle.
- sec_pend_o and sec_pend_addr_o reflect the buffer registers directly.
- Address-0 writes are forwarded unchanged; the register file handles R0 semantics.
- RV32E=1: err_o is a registered flag, set one cycle after the offending sec_valid_i and sticky until reset. The offending write is still buffered with address bit 4 cleared.
- Reset asserted mid-wipe or mid-buffer: all state is abandoned immediately. Behaviour after release is identical to power-on.

Test Plan:
- WipeOnReset=1, release reset -> wipe_busy_o=1 for 31 cycles, waddr_a_o=1..31, wdata_a_o=WipeVal, then RUN with prim_ready_o=1.
- RUN, sec write x5=0xDEADBEEF with the primary idle -> sec_ready_o=1 in cycle N, we_a_o/waddr_a_o=5/wdata_a_o=0xDEADBEEF in N+1, sec_pend_o=1 during N+1, 0 in N+2.
- Buffered x7 with continuous primary writes to x3, StarveLimit=4 -> primary wins for 4 cycles, 5th cycle writes x7 with prim_ready_o=0, primary resumes next cycle.
- Buffered x9=0x11, primary writes x9=0x22 -> buffer dropped, x9 written once with 0x22, sec_pend_o=0 next cycle.
- wipe_req_i pulsed while buffer holds x4 -> buffer discarded, 31 wipe writes follow, x4 is never written with the old data.
- RV32E=1, secondary address 5'h13 -> err_o=1 from the next cycle and stays set; write lands at x3; wipe lasts 15 cycles.

Source files
------------

// File: rtl/ibex_rf_wr_arbiter.sv
// rtl/ibex_rf_wr_arbiter.sv - register-file write-port arbiter with secure wipe and late-writeback buffer
module ibex_rf_wr_arbiter #(
  parameter bit                   RV32E       = 1'b0,
  parameter int unsigned          DataWidth   = 32,
  parameter bit                   WipeOnReset = 1'b1,
  parameter logic [DataWidth-1:0] WipeVal     = '0,
  parameter int unsigned          StarveLimit = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 wipe_req_i,
  output logic                 wipe_busy_o,
  input  logic                 prim_we_i,
  input  logic [4:0]           prim_waddr_i,
  input  logic [DataWidth-1:0] prim_wdata_i,
  output logic                 prim_ready_o,
  input  logic                 sec_valid_i,
  input  logic [4:0]           sec_waddr_i,
  input  logic [DataWidth-1:0] sec_wdata_i,
  output logic                 sec_ready_o,
  output logic                 sec_pend_o,
  output logic [4:0]           sec_pend_addr_o,
  output logic                 we_a_o,
  output logic [4:0]           waddr_a_o,
  output logic [DataWidth-1:0] wdata_a_o,
  output logic                 err_o
);
  localparam int unsigned NumWords  = RV32E ? 16 : 32;
  localparam logic [4:0]  LastAddr  = 5'(NumWords - 1);
  localparam logic [3:0]  StarveLim = 4'(StarveLimit);

  typedef enum logic {ST_WIPE, ST_RUN} state_e;

  state_e               state_q;
  logic [4:0]           wipe_cnt_q;
  logic                 buf_valid_q;
  logic [4:0]           buf_addr_q;
  logic [DataWidth-1:0] buf_data_q;
  logic [3:0]           starve_q;
  logic                 sec_ready_q;
  logic                 err_q;

  logic       run, starved, prim_wr, buf_wr, waw_drop, sec_accept, sec_bad;
  logic [4:0] sec_addr_eff;

  always_comb begin
    run          = (state_q == ST_RUN);
    starved      = buf_valid_q && (starve_q >= StarveLim);
    prim_ready_o = run && !starved;
    prim_wr      = prim_ready_o && prim_we_i;
    buf_wr       = run && buf_valid_q && (starved || !prim_we_i);
    // The primary is the newer producer, so a matching buffered write is stale.
    waw_drop     = prim_wr && buf_valid_q && (prim_waddr_i == buf_addr_q) &&
                   (prim_waddr_i != 5'd0);
    sec_accept   = sec_valid_i && sec_ready_q;
    sec_bad      = RV32E && sec_valid_i && sec_waddr_i[4];
    sec_addr_eff = RV32E ? {1'b0, sec_waddr_i[3:0]} : sec_waddr_i;

    we_a_o    = 1'b0;
    waddr_a_o = '0;
    wdata_a_o = '0;
    if (!run) begin
      we_a_o    = 1'b1;
      waddr_a_o = wipe_cnt_q;
      wdata_a_o = WipeVal;
    end else if (buf_wr) begin
      we_a_o    = 1'b1;
      waddr_a_o = buf_addr_q;
      wdata_a_o = buf_data_q;
    end else if (prim_wr) begin
      we_a_o    = 1'b1;
      waddr_a_o = prim_waddr_i;
      wdata_a_o = prim_wdata_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= WipeOnReset ? ST_WIPE : ST_RUN;
      wipe_cnt_q  <= 5'd1;
      buf_valid_q <= 1'b0;
      buf_addr_q  <= '0;
      buf_data_q  <= '0;
      starve_q    <= '0;
      sec_ready_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      if (sec_bad) begin
        err_q <= 1'b1;
      end
      case (state_q)
        ST_WIPE: begin
          if (wipe_cnt_q == LastAddr) begin
            state_q     <= ST_RUN;
            wipe_cnt_q  <= 5'd1;
            sec_ready_q <= 1'b1;
          end else begin
            wipe_cnt_q <= wipe_cnt_q + 5'd1;
          end
        end
        ST_RUN: begin
          if (wipe_req_i) begin
            // Discarding the buffer keeps pre-wipe data from landing after the wipe.
            state_q     <= ST_WIPE;
            wipe_cnt_q  <= 5'd1;
            buf_valid_q <= 1'b0;
            starve_q    <= '0;
            sec_ready_q <= 1'b0;
          end else if (buf_wr || waw_drop) begin
            buf_valid_q <= 1'b0;
            starve_q    <= '0;
            sec_ready_q <= 1'b1;
          end else if (buf_valid_q) begin
            if (starve_q != 4'hF) begin
              starve_q <= starve_q + 4'd1;
            end
            sec_ready_q <= 1'b0;
          end else if (sec_accept) begin
            buf_valid_q <= 1'b1;
            buf_addr_q  <= sec_addr_eff;
            buf_data_q  <= sec_wdata_i;
            sec_ready_q <= 1'b0;
          end else begin
            sec_ready_q <= 1'b1;
          end
        end
      endcase
    end
  end

  assign wipe_busy_o     = (state_q == ST_WIPE);
  assign sec_ready_o     = sec_ready_q;
  assign sec_pend_o      = buf_valid_q;
  assign sec_pend_addr_o = buf_addr_q;
  assign err_o           = err_q;

endmodule

// File: tb/tb_ibex_rf_wr_arbiter.sv
// tb/tb_ibex_rf_wr_arbiter.sv - randomized check of ibex_rf_wr_arbiter (RV32I and RV32E) against a reference model
module tb_ibex_rf_wr_arbiter;
  localparam logic [31:0] WIPE_VAL = 32'hC0FF_EE00;
  localparam int          STARVE   = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        wipe_req[2], prim_we[2], sec_valid[2];
  logic [4:0]  prim_waddr[2], sec_waddr[2];
  logic [31:0] prim_wdata[2], sec_wdata[2];
  logic        wipe_busy[2], prim_ready[2], sec_ready[2], sec_pend[2], we_a[2], err[2];
  logic [4:0]  sec_pend_addr[2], waddr_a[2];
  logic [31:0] wdata_a[2];

  ibex_rf_wr_arbiter #(.RV32E(1'b0), .DataWidth(32), .WipeOnReset(1'b1),
                       .WipeVal(WIPE_VAL), .StarveLimit(STARVE)) dut (
    .clk_i(clk), .rst_ni(rst_n), .wipe_req_i(wipe_req[0]), .wipe_busy_o(wipe_busy[0]),
    .prim_we_i(prim_we[0]), .prim_waddr_i(prim_waddr[0]), .prim_wdata_i(prim_wdata[0]),
    .prim_ready_o(prim_ready[0]), .sec_valid_i(sec_valid[0]), .sec_waddr_i(sec_waddr[0]),
    .sec_wdata_i(sec_wdata[0]), .sec_ready_o(sec_ready[0]), .sec_pend_o(sec_pend[0]),
    .sec_pend_addr_o(sec_pend_addr[0]), .we_a_o(we_a[0]), .waddr_a_o(waddr_a[0]),
    .wdata_a_o(wdata_a[0]), .err_o(err[0]));

  ibex_rf_wr_arbiter #(.RV32E(1'b1), .DataWidth(32), .WipeOnReset(1'b1),
                       .WipeVal(WIPE_VAL), .StarveLimit(STARVE)) dut_e (
    .clk_i(clk), .rst_ni(rst_n), .wipe_req_i(wipe_req[1]), .wipe_busy_o(wipe_busy[1]),
    .prim_we_i(prim_we[1]), .prim_waddr_i(prim_waddr[1]), .prim_wdata_i(prim_wdata[1]),
    .prim_ready_o(prim_ready[1]), .sec_valid_i(sec_valid[1]), .sec_waddr_i(sec_waddr[1]),
    .sec_wdata_i(sec_wdata[1]), .sec_ready_o(sec_ready[1]), .sec_pend_o(sec_pend[1]),
    .sec_pend_addr_o(sec_pend_addr[1]), .we_a_o(we_a[1]), .waddr_a_o(waddr_a[1]),
    .wdata_a_o(wdata_a[1]), .err_o(err[1]));

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s cycle=%0d got=%0h exp=%0h", tag, cyc, got, exp);
  endtask

  // Model: set of addresses still to wipe, a one-entry pending list and a wait count.
  logic [31:0] to_wipe[2];
  bit          pv[2];
  logic [4:0]  pa[2];
  logic [31:0] pd[2];
  int          waited[2];
  bit          merr[2];

  function automatic logic [31:0] wipe_set(input int i);
    logic [31:0] s = '0;
    for (int a = 1; a < ((i == 0) ? 32 : 16); a++) s[a] = 1'b1;
    return s;
  endfunction

  task automatic model_reset(input int i);
    to_wipe[i] = wipe_set(i);
    pv[i] = 0; pa[i] = '0; pd[i] = '0; waited[i] = 0; merr[i] = 0;
  endtask

  task automatic check_and_step(input int i);
    bit busy, hold, e_we, e_pr, e_sr, pw, drop;
    logic [4:0]  e_addr;
    logic [31:0] e_data;
    int low;
    busy = (to_wipe[i] != 0);
    low = 0;
    for (int b = 31; b >= 0; b--) if (to_wipe[i][b]) low = b;
    hold = pv[i] && (waited[i] >= STARVE);
    e_sr = !busy && !pv[i];
    e_pr = !busy && !hold;
    pw   = 0;
    e_we = 0; e_addr = '0; e_data = '0;
    if (busy) begin
      e_we = 1; e_addr = 5'(low); e_data = WIPE_VAL;
    end else if (hold || (pv[i] && !prim_we[i])) begin
      e_we = 1; e_addr = pa[i]; e_data = pd[i];
    end else if (prim_we[i]) begin
      e_we = 1; e_addr = prim_waddr[i]; e_data = prim_wdata[i]; pw = 1;
    end
    check_eq($sformatf("i%0d.wipe_busy", i), 64'(wipe_busy[i]), 64'(busy));
    check_eq($sformatf("i%0d.prim_ready", i), 64'(prim_ready[i]), 64'(e_pr));
    check_eq($sformatf("i%0d.sec_ready", i), 64'(sec_ready[i]), 64'(e_sr));
    check_eq($sformatf("i%0d.sec_pend", i), 64'(sec_pend[i]), 64'(pv[i]));
    check_eq($sformatf("i%0d.sec_pend_addr", i), 64'(sec_pend_addr[i]), 64'(pa[i]));
    check_eq($sformatf("i%0d.we", i), 64'(we_a[i]), 64'(e_we));
    check_eq($sformatf("i%0d.waddr", i), 64'(waddr_a[i]), 64'(e_addr));
    check_eq($sformatf("i%0d.wdata", i), 64'(wdata_a[i]), 64'(e_data));
    check_eq($sformatf("i%0d.err", i), 64'(err[i]), 64'(merr[i]));
    if (!rst_n) return;
    if (busy) begin
      to_wipe[i][low] = 1'b0;
    end else if (wipe_req[i]) begin
      to_wipe[i] = wipe_set(i); pv[i] = 0; waited[i] = 0;
    end else begin
      drop = pw && pv[i] && (prim_waddr[i] == pa[i]) && (pa[i] != 0);
      if ((pv[i] && !pw) || drop) begin
        pv[i] = 0; waited[i] = 0;
      end else if (pv[i]) begin
        waited[i]++;
      end else if (sec_valid[i] && e_sr) begin
        pv[i] = 1; pa[i] = (i == 1) ? (sec_waddr[i] & 5'h0F) : sec_waddr[i];
        pd[i] = sec_wdata[i]; waited[i] = 0;
      end
    end
    if (i == 1 && sec_valid[i] && sec_waddr[i][4]) merr[i] = 1;
  endtask

  function automatic logic [4:0] hot_addr();
    case ($urandom_range(0, 3))
      0: return 5'd0;
      1: return 5'd5;
      default: return 5'd9;
    endcase
  endfunction

  // mode 0: random, 1: primary hammering x3 (starvation), 2: colliding addresses, 3: random incl. RV32E bad addresses
  task automatic drive(input int mode, input int i);
    wipe_req[i]   = (mode != 1) && ($urandom_range(0, 99) == 0);
    prim_we[i]    = (mode == 1) ? 1'b1 : 1'($urandom_range(0, 1));
    prim_wdata[i] = $urandom;
    sec_valid[i]  = 1'($urandom_range(0, 1));
    sec_wdata[i]  = $urandom;
    case (mode)
      1: begin prim_waddr[i] = 5'd3; sec_waddr[i] = 5'd7; end
      2: begin prim_waddr[i] = hot_addr(); sec_waddr[i] = hot_addr(); end
      default: begin
        prim_waddr[i] = 5'($urandom_range(0, 31));
        sec_waddr[i]  = (i == 1 && mode != 3) ? 5'($urandom_range(0, 15))
                                              : 5'($urandom_range(0, 31));
      end
    endcase
  endtask

  task automatic run_cycles(input int n, input int mode, input bit rst_val);
    repeat (n) begin
      @(negedge clk);
      rst_n = rst_val;
      for (int i = 0; i < 2; i++) begin
        drive(mode, i);
        if (!rst_n) model_reset(i);
      end
      #1;
      for (int i = 0; i < 2; i++) check_and_step(i);
      cyc++;
    end
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      wipe_req[i] = 0; prim_we[i] = 0; sec_valid[i] = 0;
      prim_waddr[i] = '0; sec_waddr[i] = '0; prim_wdata[i] = '0; sec_wdata[i] = '0;
      model_reset(i);
    end
    run_cycles(3, 0, 1'b0);
    run_cycles(60, 1, 1'b1);
    run_cycles(100, 2, 1'b1);
    run_cycles(300, 0, 1'b1);
    run_cycles(2, 0, 1'b0);
    run_cycles(60, 2, 1'b1);
    run_cycles(100, 3, 1'b1);
    run_cycles(40, 1, 1'b1);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
